// File: rtl/adsr_pkg.sv
// Shared types and default widths for the ADSR envelope generator and its tick divider.
package adsr_pkg;

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} adsr_state_t;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ENV_W      = 12;
  localparam int DEF_SAMPLE_DIV = 500;
  localparam int DEF_REL_SHIFT  = 6;

endpackage

// File: rtl/adsr_envelope_sample_tick_gen.sv
// Free-running divider: one-clk tick every SAMPLE_DIV clocks, in the last count before wrap.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 500
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate-driven envelope updated once per sample tick, scaling sample_in.
// Define EXP_RELEASE_EN for an exponential release (env -= max(env>>REL_SHIFT, 1)).
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ENV_W      = DEF_ENV_W,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int REL_SHIFT  = DEF_REL_SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gate_raw,
  input  logic [ENV_W-1:0]  atk_step,
  input  logic [ENV_W-1:0]  dec_step,
  input  logic [ENV_W-1:0]  sus_level,
  input  logic [ENV_W-1:0]  rel_step,
  input  logic [DATA_W-1:0] sample_in,
  output logic              sample_tick,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid,
  output logic [ENV_W-1:0]  env_level,
  output logic              done
);

  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  localparam int PROD_W = DATA_W + ENV_W + 1;

  if (SAMPLE_DIV < 4 || REL_SHIFT < 0 || REL_SHIFT >= ENV_W) begin : g_bad_param
    $error("adsr_envelope: SAMPLE_DIV must be >= 4 and REL_SHIFT within 0..ENV_W-1");
  end

  adsr_state_t              state_reg;
  adsr_state_t              eff_state;
  logic [ENV_W-1:0]         env_reg;
  logic                     gate_meta_reg;
  logic                     gate_s_reg;
  logic signed [DATA_W-1:0] sample_reg;
  logic                     pend_reg;
  logic                     done_reg;
  logic                     valid_reg;
  logic [DATA_W-1:0]        sample_out_reg;

  logic [ENV_W:0]           atk_sum;
  logic [ENV_W:0]           dec_diff;
  logic [ENV_W:0]           rel_diff;
  logic [ENV_W-1:0]         env_atk;
  logic [ENV_W-1:0]         env_dec;
  logic [ENV_W-1:0]         env_rel;
  logic signed [PROD_W-1:0] product;
`ifdef EXP_RELEASE_EN
  logic [ENV_W-1:0]         rel_amt;
`endif

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (sample_tick)
  );

  // Candidate next-envelope values, computed one bit wide so they saturate instead of wrapping.
  always_comb begin
    atk_sum = {1'b0, env_reg} + {1'b0, atk_step};
    if (atk_step == '0 || atk_sum[ENV_W]) env_atk = ENV_MAX;
    else                                  env_atk = atk_sum[ENV_W-1:0];

    dec_diff = {1'b0, env_reg} - {1'b0, dec_step};
    if (dec_step == '0 || dec_diff[ENV_W] || dec_diff[ENV_W-1:0] < sus_level) env_dec = sus_level;
    else                                                                     env_dec = dec_diff[ENV_W-1:0];

`ifdef EXP_RELEASE_EN
    rel_amt = env_reg >> REL_SHIFT;
    if (rel_amt == '0) rel_amt = ENV_W'(1);
    rel_diff = {1'b0, env_reg} - {1'b0, rel_amt};
    env_rel  = rel_diff[ENV_W] ? '0 : rel_diff[ENV_W-1:0];
`else
    rel_diff = {1'b0, env_reg} - {1'b0, rel_step};
    env_rel  = (rel_step == '0 || rel_diff[ENV_W]) ? '0 : rel_diff[ENV_W-1:0];
`endif

    // Gate edges override the current phase; the new phase's rule then applies in the same tick.
    eff_state = state_reg;
    if (gate_s_reg && (state_reg == IDLE || state_reg == RELEASE)) begin
      eff_state = ATTACK;
    end else if (!gate_s_reg && (state_reg == ATTACK || state_reg == DECAY || state_reg == SUSTAIN)) begin
      eff_state = RELEASE;
    end
  end

  assign product = $signed({{(ENV_W+1){sample_reg[DATA_W-1]}}, sample_reg})
                 * $signed({{DATA_W{1'b0}}, env_reg});

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      env_reg        <= '0;
      gate_meta_reg  <= 1'b0;
      gate_s_reg     <= 1'b0;
      sample_reg     <= '0;
      pend_reg       <= 1'b0;
      done_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      sample_out_reg <= '0;
    end else begin
      gate_meta_reg <= gate_raw;
      gate_s_reg    <= gate_meta_reg;
      done_reg      <= 1'b0;
      pend_reg      <= sample_tick;
      valid_reg     <= pend_reg;

      if (pend_reg) begin
        sample_out_reg <= DATA_W'(product >>> ENV_W);
      end

      if (sample_tick) begin
        sample_reg <= $signed(sample_in);
        case (eff_state)
          ATTACK: begin
            env_reg   <= env_atk;
            state_reg <= (env_atk == ENV_MAX) ? DECAY : ATTACK;
          end
          DECAY: begin
            env_reg   <= env_dec;
            state_reg <= (env_dec == sus_level) ? SUSTAIN : DECAY;
          end
          SUSTAIN: begin
            env_reg   <= sus_level;
            state_reg <= SUSTAIN;
          end
          RELEASE: begin
            // An envelope already at zero while releasing finishes the note.
            if (state_reg == RELEASE && env_reg == '0) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end else begin
              env_reg   <= env_rel;
              state_reg <= RELEASE;
            end
          end
          default: begin
            env_reg   <= '0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign env_level  = env_reg;
  assign done       = done_reg;
  assign out_valid  = valid_reg;
  assign sample_out = sample_out_reg;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: tick timing, full envelope, retrigger, reset, zero steps.
module tb_adsr_envelope;

  localparam int DATA_W = 16;
  localparam int ENV_W  = 12;
  localparam int SD     = 500;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              gate_raw = 1'b0;
  logic [ENV_W-1:0]  atk_step = '0;
  logic [ENV_W-1:0]  dec_step = '0;
  logic [ENV_W-1:0]  sus_level = '0;
  logic [ENV_W-1:0]  rel_step = '0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_tick;
  logic [DATA_W-1:0] sample_out;
  logic              out_valid;
  logic [ENV_W-1:0]  env_level;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_sample = 0;

  adsr_envelope #(.DATA_W(DATA_W), .ENV_W(ENV_W), .SAMPLE_DIV(SD), .REL_SHIFT(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .gate_raw    (gate_raw),
    .atk_step    (atk_step),
    .dec_step    (dec_step),
    .sus_level   (sus_level),
    .rel_step    (rel_step),
    .sample_in   (sample_in),
    .sample_tick (sample_tick),
    .sample_out  (sample_out),
    .out_valid   (out_valid),
    .env_level   (env_level),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", tag, got, exp);
    end
  endtask

  task automatic set_sample(input int s);
    sample_in  = DATA_W'(s);
    cur_sample = s;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_tick(input string tag, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (sample_tick !== 1'b1 && n < SD + 50) begin
      @(negedge clk);
      n++;
    end
    ok = (sample_tick === 1'b1);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s tick timeout: got no sample_tick within %0d clks, required one", tag, n);
    end
  endtask

  // Checks the registered envelope one clk after a tick, then the scaled sample one clk later.
  task automatic tick_check(input string tag, input int exp_env, input int exp_done);
    bit     ok;
    longint p;
    int     exp_out;
    wait_tick(tag, ok);
    if (!ok) return;
    @(negedge clk);
    check({tag, " env"}, int'(env_level), exp_env);
    check({tag, " done"}, int'(done), exp_done);
    check({tag, " valid early"}, int'(out_valid), 0);
    @(negedge clk);
    p = longint'(cur_sample) * longint'(exp_env);
    exp_out = int'(p >>> ENV_W);
    check({tag, " valid"}, int'(out_valid), 1);
    check({tag, " out"}, int'($signed(sample_out)), exp_out);
    check({tag, " done width"}, int'(done), 0);
    $display("tick %-10s env=%0d (exp %0d) out=%0d (exp %0d)", tag, env_level, exp_env,
             $signed(sample_out), exp_out);
  endtask

  int atk_env[10] = '{1024, 2048, 3072, 4095, 3583, 3071, 2559, 2048, 2048, 2048};

  initial begin
    int n;
    bit ok;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst env", int'(env_level), 0);
    check("rst tick", int'(sample_tick), 0);
    check("rst valid", int'(out_valid), 0);
    check("rst done", int'(done), 0);
    check("rst out", int'(sample_out), 0);
    $display("reset: env=%0d tick=%0d valid=%0d done=%0d", env_level, sample_tick, out_valid, done);
    reset = 1'b1;

    // Tick period and width
    n = 0;
    while (sample_tick !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("first tick clks", n, 499);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("tick width", int'(sample_tick), 0);
    end while (sample_tick !== 1'b1 && n < 600);
    check("tick period", n, 500);
    $display("tick: first after %0d clks, period %0d", 499, n);

    // Full envelope
    atk_step = 12'd1024; dec_step = 12'd512; sus_level = 12'd2048; rel_step = 12'd1024;
    set_sample(16384);
    gate_raw = 1'b1;
    foreach (atk_env[i]) tick_check($sformatf("env%0d", i), atk_env[i], 0);
    gate_raw = 1'b0;
`ifdef EXP_RELEASE_EN
    tick_check("rel0", 2016, 0);
    tick_check("rel1", 1985, 0);
`else
    tick_check("rel0", 1024, 0);
    tick_check("rel1", 0, 0);
    tick_check("rel_done", 0, 1);
    tick_check("idle", 0, 0);
`endif

    // Retrigger from release with no clear, negative sample scaling
    pulse_reset();
    atk_step = 12'd4095; dec_step = 12'd1095; sus_level = 12'd2048; rel_step = 12'd1024;
    set_sample(-32768);
    gate_raw = 1'b1;
    tick_check("rt_atk", 4095, 0);
    tick_check("rt_dec", 3000, 0);
    gate_raw = 1'b0;
`ifdef EXP_RELEASE_EN
    tick_check("rt_rel", 2954, 0);
    gate_raw = 1'b1; atk_step = 12'd100;
    tick_check("rt_re", 3054, 0);
`else
    tick_check("rt_rel", 1976, 0);
    gate_raw = 1'b1; atk_step = 12'd100;
    tick_check("rt_re", 2076, 0);
`endif

    // Reset asserted in the tick cycle drops the in-flight sample
    wait_tick("rst_mid", ok);
    if (ok) begin
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("rst_mid env", int'(env_level), 0);
      check("rst_mid done", int'(done), 0);
      check("rst_mid valid", int'(out_valid), 0);
      @(negedge clk);
      check("rst_mid valid2", int'(out_valid), 0);
      $display("reset mid-attack: env=%0d valid=%0d done=%0d", env_level, out_valid, done);
    end
    tick_check("post_rst", 100, 0);

    // Zero steps: jumps straight to each target
    pulse_reset();
    atk_step = '0; dec_step = '0; rel_step = '0; sus_level = 12'd1500;
    set_sample(16384);
    gate_raw = 1'b1;
    tick_check("z_atk", 4095, 0);
`ifdef EXP_RELEASE_EN
    gate_raw = 1'b0;
    tick_check("x_rel0", 4032, 0);
    tick_check("x_rel1", 3969, 0);
`else
    tick_check("z_dec", 1500, 0);
    sus_level = 12'd1600;
    tick_check("z_sus", 1600, 0);
    gate_raw = 1'b0;
    tick_check("z_rel", 0, 0);
    tick_check("z_done", 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
